serial_frame_rx: RTL and testbench

//   Receiver end of the single-bit serial link carried through the Passthru chain (I -> O).

---
 rtl/serial_frame_rx.sv | 129 ++++++++++++
 tb/tb_serial_frame_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial line deframer: start / LSB-first data / optional even parity / stop, delivering each
// good word through a one-entry valid/ready buffer with sticky error flags and a frame counter.
module serial_frame_rx #(
   parameter int WIDTH       = 8,
   parameter int PARITY_EN   = 1,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   I,
   output logic [WIDTH-1:0]       O_data,
   output logic                   O_valid,
   input  logic                   O_ready,
   output logic                   parity_err,
   output logic                   frame_err,
   output logic                   overrun,
   input  logic                   clear_err,
   output logic [COUNT_WIDTH-1:0] frame_count,
   output logic [2:0]             dbg_state
);

   localparam int IW = $clog2(WIDTH + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_RESYNC = 3'd0,
      ST_IDLE   = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Handshake: a word moves to the consumer in any cycle where O_valid and O_ready are both 1;
   // O_valid never falls without such a transfer and O_data is frozen while O_valid is held.

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [WIDTH-1:0]        r_shift;
   logic [IW-1:0]           r_bit_idx;
   logic                    r_par_bad;
   logic [WIDTH-1:0]        r_data;
   logic                    r_valid;
   logic                    r_par_err;
   logic                    r_frm_err;
   logic                    r_ovr;
   logic [COUNT_WIDTH-1:0]  r_count;

   logic w_take;
   logic w_free;
   logic w_good;
   logic w_load;
   logic w_ovr_set;
   logic w_frm_set;
   logic w_par_set;

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= ST_RESYNC;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RESYNC: if (I)  w_state_nxt = ST_IDLE;
         ST_IDLE:   if (!I) w_state_nxt = ST_DATA;
         ST_DATA:   if (r_bit_idx == LAST_IDX)
                       w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
         ST_PARITY: w_state_nxt = ST_STOP;
         ST_STOP:   w_state_nxt = I ? ST_IDLE : ST_RESYNC;
         default:   w_state_nxt = ST_RESYNC;
      endcase
   end

   always_comb begin
      w_take    = r_valid & O_ready;
      w_free    = ~r_valid | w_take;
      w_good    = (r_state == ST_STOP) & I & ~r_par_bad;
      w_load    = w_good & w_free;
      w_ovr_set = w_good & ~w_free;
      w_frm_set = (r_state == ST_STOP) & ~I;
      w_par_set = (r_state == ST_STOP) & I & r_par_bad;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_par_bad <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
         r_ovr     <= 1'b0;
         r_count   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (!I) begin
               r_shift   <= '0;
               r_bit_idx <= '0;
               r_par_bad <= 1'b0;
            end
            ST_DATA: begin
               r_shift[r_bit_idx] <= I;
               r_bit_idx          <= r_bit_idx + IW'(1);
            end
            ST_PARITY: r_par_bad <= I ^ (^r_shift);
            default: ;
         endcase
         if (w_load) begin
            r_data  <= r_shift;
            r_count <= r_count + COUNT_WIDTH'(1);
         end
         r_valid   <= w_load | (r_valid & ~w_take);
         // A new error in the same cycle as clear_err keeps the flag set.
         r_par_err <= w_par_set | (r_par_err & ~clear_err);
         r_frm_err <= w_frm_set | (r_frm_err & ~clear_err);
         r_ovr     <= w_ovr_set | (r_ovr & ~clear_err);
      end
   end

   assign O_data      = r_data;
   assign O_valid     = r_valid;
   assign parity_err  = r_par_err;
   assign frame_err   = r_frm_err;
   assign overrun     = r_ovr;
   assign frame_count = r_count;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: one parity-enabled instance for the main scenarios and one
// parity-less, 2-bit-counter instance for counter wrap.
module tb_serial_frame_rx;

   logic        CLK;
   logic        rst0, rst1;
   logic        I0, I1;
   logic        O_ready0, O_ready1;
   logic        clear0, clear1;
   logic [7:0]  O_data0, O_data1;
   logic        O_valid0, O_valid1;
   logic        perr0, ferr0, ovr0;
   logic        perr1, ferr1, ovr1;
   logic [15:0] cnt0;
   logic [1:0]  cnt1;
   logic [2:0]  st0, st1;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] exp0_q[$];
   logic [7:0] exp1_q[$];

   serial_frame_rx #(.WIDTH(8), .PARITY_EN(1), .COUNT_WIDTH(16)) dut0 (
      .CLK(CLK), .RESET(rst0), .I(I0), .O_data(O_data0), .O_valid(O_valid0),
      .O_ready(O_ready0), .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0),
      .clear_err(clear0), .frame_count(cnt0), .dbg_state(st0));

   serial_frame_rx #(.WIDTH(8), .PARITY_EN(0), .COUNT_WIDTH(2)) dut1 (
      .CLK(CLK), .RESET(rst1), .I(I1), .O_data(O_data1), .O_valid(O_valid1),
      .O_ready(O_ready1), .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1),
      .clear_err(clear1), .frame_count(cnt1), .dbg_state(st1));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard: every transfer on either instance must match the head of its queue.
   always @(negedge CLK) begin
      if (!rst0 && O_valid0 && O_ready0) begin
         if (exp0_q.size() == 0) check_eq("xfer0_unexpected", {24'd0, O_data0}, 32'hFFFF_FFFF);
         else                    check_eq("xfer0_data", {24'd0, O_data0}, {24'd0, exp0_q.pop_front()});
      end
      if (!rst1 && O_valid1 && O_ready1) begin
         if (exp1_q.size() == 0) check_eq("xfer1_unexpected", {24'd0, O_data1}, 32'hFFFF_FFFF);
         else                    check_eq("xfer1_data", {24'd0, O_data1}, {24'd0, exp1_q.pop_front()});
      end
   end

   task automatic drive_bit(input int which, input logic b);
      if (which == 0) I0 = b;
      else            I1 = b;
      @(posedge CLK);
      #1;
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Parity bit only goes on the line for instance 0.
   task automatic send_frame(input int which, input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic p;
      p = (^d) ^ bad_par;
      drive_bit(which, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
      if (which == 0) drive_bit(which, p);
      drive_bit(which, ~bad_stop);
   endtask

   task automatic pulse_clear0();
      clear0 = 1'b1;
      tick(1);
      clear0 = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic [1:0] exp_cnt;
      rst0 = 1'b1; rst1 = 1'b1;
      I0 = 1'b1; I1 = 1'b1;
      O_ready0 = 1'b1; O_ready1 = 1'b1;
      clear0 = 1'b0; clear1 = 1'b0;
      tick(2);
      check_eq("rst_valid", {31'd0, O_valid0}, 32'd0);
      check_eq("rst_data", {24'd0, O_data0}, 32'd0);
      check_eq("rst_count", {16'd0, cnt0}, 32'd0);
      check_eq("rst_flags", {29'd0, perr0, ferr0, ovr0}, 32'd0);
      check_eq("rst_state", {29'd0, st0}, 32'd0);
      rst0 = 1'b0; rst1 = 1'b0;

      // 1: single frame, consumer ready
      tick(3);
      exp0_q.push_back(8'hA5);
      send_frame(0, 8'hA5, 1'b0, 1'b0);
      check_eq("t1_valid", {31'd0, O_valid0}, 32'd1);
      check_eq("t1_data", {24'd0, O_data0}, 32'hA5);
      check_eq("t1_count", {16'd0, cnt0}, 32'd1);
      tick(1);
      check_eq("t1_valid_drop", {31'd0, O_valid0}, 32'd0);

      // 2: back-to-back frames into a stalled buffer
      O_ready0 = 1'b0;
      exp0_q.push_back(8'h3C);
      send_frame(0, 8'h3C, 1'b0, 1'b0);
      send_frame(0, 8'hFF, 1'b0, 1'b0);
      send_frame(0, 8'h00, 1'b0, 1'b0);
      check_eq("t2_valid", {31'd0, O_valid0}, 32'd1);
      check_eq("t2_data_held", {24'd0, O_data0}, 32'h3C);
      check_eq("t2_overrun", {31'd0, ovr0}, 32'd1);
      check_eq("t2_count", {16'd0, cnt0}, 32'd2);
      O_ready0 = 1'b1;
      tick(1);
      check_eq("t2_valid_drop", {31'd0, O_valid0}, 32'd0);
      pulse_clear0();
      check_eq("t2_ovr_clear", {31'd0, ovr0}, 32'd0);

      // 3: bad parity, then clear_err held during a second bad frame (error wins)
      send_frame(0, 8'h01, 1'b1, 1'b0);
      check_eq("t3_no_valid", {31'd0, O_valid0}, 32'd0);
      check_eq("t3_perr", {31'd0, perr0}, 32'd1);
      pulse_clear0();
      check_eq("t3_perr_clear", {31'd0, perr0}, 32'd0);
      clear0 = 1'b1;
      send_frame(0, 8'h5A, 1'b1, 1'b0);
      check_eq("t3_err_beats_clear", {31'd0, perr0}, 32'd1);
      clear0 = 1'b0;
      pulse_clear0();
      check_eq("t3_count", {16'd0, cnt0}, 32'd2);

      // 4: framing error, line held low, recovery
      send_frame(0, 8'h55, 1'b0, 1'b1);
      check_eq("t4_ferr", {31'd0, ferr0}, 32'd1);
      check_eq("t4_state_resync", {29'd0, st0}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         drive_bit(0, 1'b0);
         check_eq("t4_low_no_valid", {31'd0, O_valid0}, 32'd0);
         check_eq("t4_low_resync", {29'd0, st0}, 32'd0);
      end
      drive_bit(0, 1'b1);
      exp0_q.push_back(8'h66);
      send_frame(0, 8'h66, 1'b0, 1'b0);
      check_eq("t4_count", {16'd0, cnt0}, 32'd3);
      pulse_clear0();
      check_eq("t4_flags_clear", {29'd0, perr0, ferr0, ovr0}, 32'd0);

      // random back-to-back traffic, consumer ready
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom_range(0, 255));
         exp0_q.push_back(d);
         send_frame(0, d, 1'b0, 1'b0);
      end
      tick(1);
      check_eq("rnd_count", {16'd0, cnt0}, 32'd11);

      // 5: held word plus mid-frame reset
      O_ready0 = 1'b0;
      send_frame(0, 8'h34, 1'b0, 1'b0);
      check_eq("t5_held_valid", {31'd0, O_valid0}, 32'd1);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b1);
      rst0 = 1'b1;
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b0);
      rst0 = 1'b0;
      check_eq("t5_valid", {31'd0, O_valid0}, 32'd0);
      check_eq("t5_data", {24'd0, O_data0}, 32'd0);
      check_eq("t5_count", {16'd0, cnt0}, 32'd0);
      check_eq("t5_flags", {29'd0, perr0, ferr0, ovr0}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         drive_bit(0, 1'b0);
         check_eq("t5_resync_hold", {29'd0, st0}, 32'd0);
      end
      drive_bit(0, 1'b1);
      check_eq("t5_idle", {29'd0, st0}, 32'd1);
      O_ready0 = 1'b1;
      exp0_q.push_back(8'h12);
      send_frame(0, 8'h12, 1'b0, 1'b0);
      check_eq("t5_rx_valid", {31'd0, O_valid0}, 32'd1);
      check_eq("t5_rx_count", {16'd0, cnt0}, 32'd1);
      tick(2);

      // 6: no-parity instance, 2-bit counter wraps
      exp_cnt = 2'd0;
      for (int k = 0; k < 5; k++) begin
         d = 8'($urandom_range(0, 255));
         exp1_q.push_back(d);
         send_frame(1, d, 1'b0, 1'b0);
         exp_cnt = exp_cnt + 2'd1;
         check_eq("t6_valid", {31'd0, O_valid1}, 32'd1);
         check_eq("t6_count", {30'd0, cnt1}, {30'd0, exp_cnt});
      end
      tick(2);
      check_eq("t6_flags", {29'd0, perr1, ferr1, ovr1}, 32'd0);

      check_eq("q0_drained", exp0_q.size(), 32'd0);
      check_eq("q1_drained", exp1_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
